serial_subtractor4: RTL and testbench



---
 rtl/arith_pkg.sv | 24 ++
 rtl/serial_subtractor4_if.sv | 37 +++
 rtl/full_subtractor.sv | 21 ++
 rtl/serial_subtractor4.sv | 120 ++++++++++++
 tb/tb_serial_subtractor4.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : arith_pkg                                                 |
// | Purpose  : Shared FSM encoding and arithmetic constants for the      |
// |            bit-serial subtractor and related arithmetic blocks.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package arith_pkg;

  // Serial-engine FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Default operand width
  localparam int c_DEFAULT_WIDTH = 4;

  // Level that signals "a borrow occurred" on bout
  localparam logic c_BORROW_ACTIVE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor4_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface: serial_subtractor4_if                                     |
// | Purpose  : Operand/result valid-ready handshake bundle for the       |
// |            serial subtractor. master = upstream/downstream agent,    |
// |            slave = the subtractor.                                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface serial_subtractor4_if
  import arith_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, busy
  );

endinterface
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : full_subtractor                                           |
// | Purpose  : One-bit full subtractor cell, x - y - z. Combinational    |
// |            counterpart of the full adder cell.                       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module full_subtractor (
  input  wire logic x,
  input  wire logic y,
  input  wire logic z,
  output logic      diff,
  output logic      borrow
);

  // Difference bit and borrow out of this bit position
  assign diff   = x ^ y ^ z;
  assign borrow = (~x & y) | (~(x ^ y) & z);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_subtractor4                                        |
// | Purpose  : Bit-serial a - b - bin, LSB first, one full-subtractor    |
// |            cell reused over WIDTH clocks. Valid/ready on both sides. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module serial_subtractor4
  import arith_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH,
  parameter int CNT_W = 3
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  serial_subtractor4_if.slave  bus
);

  // Count value at which the last bit is processed
  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_rd;
  logic               r_br;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_d;
  logic               r_bout;
  logic               r_busy;

  logic               w_diff;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_rd_next;

  // Single shared bit cell: current LSBs plus the running borrow
  full_subtractor u_fs (
    .x      (r_sa[0]),
    .y      (r_sb[0]),
    .z      (r_br),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  // Result register after this cycle's difference bit enters at the MSB
  assign w_rd_next = {w_diff, r_rd[WIDTH-1:1]};

  // FSM, operand/result shifters, counter and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sa        <= '0;
      r_sb        <= '0;
      r_rd        <= '0;
      r_br        <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_d         <= '0;
      r_bout      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_sa       <= bus.a;
            r_sb       <= bus.b;
            r_br       <= bus.bin;
            r_cnt      <= '0;
            r_state    <= SHIFT;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        SHIFT: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_rd  <= w_rd_next;
          r_br  <= w_borrow;
          r_cnt <= r_cnt + CNT_W'(1);
          // Final bit: publish the result in the same edge
          if (r_cnt == c_LAST_CNT) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_d         <= w_rd_next;
            r_bout      <= (w_borrow == c_BORROW_ACTIVE);
          end
        end

        DONE: begin
          // Result held until the consumer takes it; new operands wait for IDLE
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.d         = r_d;
  assign bus.bout      = r_bout;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_serial_subtractor4                                     |
// | Purpose  : Directed self-checking bench for serial_subtractor4.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_serial_subtractor4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_res = 0;

  serial_subtractor4_if #(.WIDTH(4)) ifc ();

  serial_subtractor4 #(.WIDTH(4), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // Count accepted operands and completed results
  always @(posedge clk) begin
    if (rst_n) begin
      if (ifc.in_valid && ifc.in_ready)   n_acc <= n_acc + 1;
      if (ifc.out_valid && ifc.out_ready) n_res <= n_res + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for in_ready, present operands for one accept edge
  task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic tbin, input string tag);
    int n;
    n = 0;
    while (!ifc.in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, " in_ready"}, 32'(ifc.in_ready), 32'd1);
    ifc.a        = ta;
    ifc.b        = tb;
    ifc.bin      = tbin;
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
  endtask

  // Called right after send: wait for out_valid and check latency and result
  task automatic expect_result(input logic [3:0] ed, input logic eb, input string tag);
    int n;
    n = 0;
    while (!ifc.out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd4);
    check({tag, " d"},       32'(ifc.d), 32'(ed));
    check({tag, " bout"},    32'(ifc.bout), 32'(eb));
    check({tag, " busy"},    32'(ifc.busy), 32'd1);
  endtask

  initial begin
    int acc0;
    int res0;
    logic seen_valid;
    logic [3:0] ed;
    logic eb;

    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.bin       = 1'b0;
    ifc.out_ready = 1'b1;

    // Reset
    #2 rst_n = 1'b0;
    #1;
    check("rst in_ready",  32'(ifc.in_ready), 32'd1);
    check("rst out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst d",         32'(ifc.d), 32'd0);
    check("rst bout",      32'(ifc.bout), 32'd0);
    check("rst busy",      32'(ifc.busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 9 - 3
    send(4'd9, 4'd3, 1'b0, "op9m3");
    check("op9m3 in_ready low", 32'(ifc.in_ready), 32'd0);
    expect_result(4'd6, 1'b0, "op9m3");
    check("op9m3 in_ready at valid", 32'(ifc.in_ready), 32'd0);
    tick();
    check("op9m3 out_valid fall", 32'(ifc.out_valid), 32'd0);
    check("op9m3 in_ready back",  32'(ifc.in_ready), 32'd1);
    check("op9m3 busy clear",     32'(ifc.busy), 32'd0);
    check("op9m3 d held",         32'(ifc.d), 32'd6);

    // 3 - 9, then 0 - 0 - 1
    send(4'd3, 4'd9, 1'b0, "op3m9");
    expect_result(4'hA, 1'b1, "op3m9");
    tick();
    send(4'd0, 4'd0, 1'b1, "op0m0b");
    expect_result(4'hF, 1'b1, "op0m0b");
    tick();

    // 15 - 15, then 15 - 0 - 1
    send(4'd15, 4'd15, 1'b0, "op15m15");
    expect_result(4'd0, 1'b0, "op15m15");
    tick();
    send(4'd15, 4'd0, 1'b1, "op15m0b");
    expect_result(4'd14, 1'b0, "op15m0b");
    tick();

    // Backpressure with an ignored operand pulse
    acc0 = n_acc;
    ifc.out_ready = 1'b0;
    send(4'd12, 4'd5, 1'b0, "bp");
    expect_result(4'd7, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        ifc.a        = 4'd1;
        ifc.b        = 4'd1;
        ifc.in_valid = 1'b1;
      end else begin
        ifc.in_valid = 1'b0;
      end
      tick();
      check("bp hold valid", 32'(ifc.out_valid), 32'd1);
      check("bp hold d",     32'(ifc.d), 32'd7);
      check("bp hold bout",  32'(ifc.bout), 32'd0);
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    tick();
    check("bp release valid", 32'(ifc.out_valid), 32'd0);
    check("bp release rdy",   32'(ifc.in_ready), 32'd1);
    tick();
    tick();
    check("bp no capture busy", 32'(ifc.busy), 32'd0);
    check("bp accept count",    32'(n_acc - acc0), 32'd1);

    // Result handshake and new operand in the same DONE cycle
    send(4'd4, 4'd1, 1'b0, "sim1");
    expect_result(4'd3, 1'b0, "sim1");
    ifc.a        = 4'd6;
    ifc.b        = 4'd1;
    ifc.bin      = 1'b0;
    ifc.in_valid = 1'b1;
    tick();
    check("sim handshake valid", 32'(ifc.out_valid), 32'd0);
    check("sim not captured",    32'(ifc.busy), 32'd0);
    check("sim rdy",             32'(ifc.in_ready), 32'd1);
    tick();
    ifc.in_valid = 1'b0;
    check("sim accepted busy", 32'(ifc.busy), 32'd1);
    expect_result(4'd5, 1'b0, "sim2");
    tick();

    // Asynchronous reset in the second SHIFT cycle
    send(4'd9, 4'd3, 1'b0, "rstmid");
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rstmid in_ready",  32'(ifc.in_ready), 32'd1);
    check("rstmid out_valid", 32'(ifc.out_valid), 32'd0);
    check("rstmid d",         32'(ifc.d), 32'd0);
    check("rstmid bout",      32'(ifc.bout), 32'd0);
    check("rstmid busy",      32'(ifc.busy), 32'd0);
    tick();
    #3 rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ifc.out_valid) seen_valid = 1'b1;
    end
    check("rstmid no out_valid", 32'(seen_valid), 32'd0);
    send(4'd5, 4'd2, 1'b0, "post_rst");
    expect_result(4'd3, 1'b0, "post_rst");
    tick();

    // Full sweep, back-to-back
    acc0 = n_acc;
    res0 = n_res;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          ed = 4'(ia - ib - ic);
          eb = (ia < (ib + ic));
          send(4'(ia), 4'(ib), 1'(ic), "sweep");
          expect_result(ed, eb, "sweep");
          tick();
        end
      end
    end
    tick();
    check("sweep accepted", 32'(n_acc - acc0), 32'd512);
    check("sweep results",  32'(n_res - res0), 32'd512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
